// File: rtl/alu_pkg.sv
// Shared opcode encodings for the 32-bit ALU and its divider.
// Any ctrl value not listed here produces a zero result.
package alu_pkg;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

endpackage

// File: rtl/alu_div32.sv
// Combinational signed 32/32 divider, truncating toward zero.
// Divide by zero returns all ones in both quotient and remainder.
module alu_div32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic        a_neg_s;
    logic        b_neg_s;
    logic [31:0] abs_a_s;
    logic [31:0] abs_b_s;
    logic [31:0] q_mag_s;
    logic [31:0] r_mag_s;

    assign a_neg_s = a_i[31];
    assign b_neg_s = b_i[31];
    assign abs_a_s = a_neg_s ? (32'h0 - a_i) : a_i;
    assign abs_b_s = b_neg_s ? (32'h0 - b_i) : b_i;

    // Magnitude division; 80000000/FFFFFFFF wraps naturally to quotient 80000000.
    assign q_mag_s = abs_a_s / abs_b_s;
    assign r_mag_s = abs_a_s % abs_b_s;

    // Restore signs: quotient negative when operand signs differ, remainder follows dividend
    always_comb begin
        quot_o = 32'h0;
        rem_o  = 32'h0;
        if (b_i == 32'h0) begin
            quot_o = 32'hFFFF_FFFF;
            rem_o  = 32'hFFFF_FFFF;
        end else begin
            quot_o = (a_neg_s ^ b_neg_s) ? (32'h0 - q_mag_s) : q_mag_s;
            rem_o  = a_neg_s ? (32'h0 - r_mag_s) : r_mag_s;
        end
    end

endmodule

// File: rtl/alu_32.sv
// 32-bit integer ALU with a single registered 64-bit result.
// 32-bit ops zero the upper word; mul and div fill all 64 bits.
module alu_32
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        clr,
    input  logic [4:0]  ctrl,
    input  logic [31:0] reg_A,
    input  logic [31:0] reg_B,
    output logic [63:0] reg_C
);

    logic [4:0]  amt_s;
    logic [63:0] rot_s;
    logic [63:0] ror_s;
    logic [63:0] rol_s;
    logic [31:0] sra_s;
    logic [63:0] mul_s;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [63:0] result_d;
    logic [63:0] result_q;

    assign amt_s = reg_B[4:0];
    assign rot_s = {reg_A, reg_A};
    assign ror_s = rot_s >> amt_s;
    assign rol_s = rot_s << amt_s;
    assign sra_s = $signed(reg_A) >>> amt_s;
    // Sign-extend both operands so the low 64 bits are the signed product.
    assign mul_s = {{32{reg_A[31]}}, reg_A} * {{32{reg_B[31]}}, reg_B};

    alu_div32 u_div (
        .a_i    (reg_A),
        .b_i    (reg_B),
        .quot_o (quot_s),
        .rem_o  (rem_s)
    );

    // Select the next result from the opcode
    always_comb begin
        result_d = 64'h0;
        case (ctrl)
            OP_ADD:  result_d = {32'h0, reg_A + reg_B};
            OP_SUB:  result_d = {32'h0, reg_A - reg_B};
            OP_AND:  result_d = {32'h0, reg_A & reg_B};
            OP_OR:   result_d = {32'h0, reg_A | reg_B};
            OP_SHR:  result_d = {32'h0, reg_A >> amt_s};
            OP_SHRA: result_d = {32'h0, sra_s};
            OP_SHL:  result_d = {32'h0, reg_A << amt_s};
            OP_ROR:  result_d = {32'h0, ror_s[31:0]};
            OP_ROL:  result_d = {32'h0, rol_s[63:32]};
            OP_MUL:  result_d = mul_s;
            OP_DIV:  result_d = {rem_s, quot_s};
            OP_NEG:  result_d = {32'h0, 32'h0 - reg_B};
            OP_NOT:  result_d = {32'h0, ~reg_B};
            default: result_d = 64'h0;
        endcase
    end

    // Result register, cleared asynchronously while clr is low
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            result_q <= 64'h0;
        end else begin
            result_q <= result_d;
        end
    end

    assign reg_C = result_q;

endmodule

// File: tb/tb_alu_32.sv
// Directed-vector bench for alu_32 with hand-computed expected results.
module tb_alu_32;

    logic        clk;
    logic        clr;
    logic [4:0]  ctrl;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic [63:0] reg_C;

    int n_checks = 0;
    int n_errors = 0;

    alu_32 dut (
        .clk   (clk),
        .clr   (clr),
        .ctrl  (ctrl),
        .reg_A (reg_A),
        .reg_B (reg_B),
        .reg_C (reg_C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one operation and check it one cycle later, just after the edge.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp);
        @(negedge clk);
        ctrl  = op;
        reg_A = a;
        reg_B = b;
        @(posedge clk);
        #1;
        check(tag, reg_C, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr   = 1'b0;
        ctrl  = 5'b00011;
        reg_A = 32'h1234_5678;
        reg_B = 32'h1111_1111;
        #1;
        check("reset_async", reg_C, 64'h0);
        @(posedge clk);
        #1;
        check("reset_held", reg_C, 64'h0);
        @(negedge clk);
        clr = 1'b1;

        run_op("add_4_4",     5'b00011, 32'd4,          32'd4,          64'h0000_0000_0000_0008);
        run_op("sub_8_4",     5'b00100, 32'd8,          32'd4,          64'h0000_0000_0000_0004);
        run_op("and",         5'b00101, 32'hFFFF_FFFF,  32'h0000_000F,  64'h0000_0000_0000_000F);
        run_op("or",          5'b00110, 32'hF0F0_F0F0,  32'h0F0F_0F0F,  64'h0000_0000_FFFF_FFFF);
        run_op("add_wrap",    5'b00011, 32'hFFFF_FFFF,  32'h0000_0001,  64'h0);
        run_op("sub_wrap",    5'b00100, 32'h8000_0000,  32'h0000_0001,  64'h0000_0000_7FFF_FFFF);
        run_op("shr",         5'b00111, 32'h8000_0000,  32'd1,          64'h0000_0000_4000_0000);
        run_op("shra",        5'b01000, 32'h8000_0000,  32'd1,          64'h0000_0000_C000_0000);
        run_op("shl",         5'b01001, 32'd1,          32'd1,          64'h0000_0000_0000_0002);
        run_op("ror",         5'b01010, 32'hA5A5_A5A5,  32'd4,          64'h0000_0000_5A5A_5A5A);
        run_op("rol",         5'b01011, 32'h5A5A_5A5A,  32'd4,          64'h0000_0000_A5A5_A5A5);
        run_op("shr_amt32",   5'b00111, 32'h8000_0000,  32'h0000_0020,  64'h0000_0000_8000_0000);
        run_op("shl_hibits",  5'b01001, 32'h0000_0003,  32'hFFFF_FFE2,  64'h0000_0000_0000_000C);
        run_op("ror_by1",     5'b01010, 32'h0000_0001,  32'd1,          64'h0000_0000_8000_0000);
        run_op("rol_by0",     5'b01011, 32'h1234_5678,  32'h0000_0040,  64'h0000_0000_1234_5678);
        run_op("shra_pos",    5'b01000, 32'h7000_0000,  32'd4,          64'h0000_0000_0700_0000);
        run_op("mul_6_7",     5'b01111, 32'd6,          32'd7,          64'h0000_0000_0000_002A);
        run_op("mul_neg",     5'b01111, 32'hFFFF_FFFF,  32'd2,          64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mul_big",     5'b01111, 32'h0001_0000,  32'h0001_0000,  64'h0000_0001_0000_0000);
        run_op("mul_negneg",  5'b01111, 32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000);
        run_op("div_42_6",    5'b10000, 32'd42,         32'd6,          64'h0000_0000_0000_0007);
        run_op("div_43_6",    5'b10000, 32'd43,         32'd6,          64'h0000_0001_0000_0007);
        run_op("div_m7_2",    5'b10000, 32'hFFFF_FFF9,  32'd2,          64'hFFFF_FFFF_FFFF_FFFD);
        run_op("div_7_m2",    5'b10000, 32'd7,          32'hFFFF_FFFE,  64'h0000_0001_FFFF_FFFD);
        run_op("div_m7_m2",   5'b10000, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  64'hFFFF_FFFF_0000_0003);
        run_op("div_ovf",     5'b10000, 32'h8000_0000,  32'hFFFF_FFFF,  64'h0000_0000_8000_0000);
        run_op("div_zero",    5'b10000, 32'd123,        32'd0,          64'hFFFF_FFFF_FFFF_FFFF);
        run_op("neg",         5'b10001, 32'hDEAD_BEEF,  32'd1234,       64'h0000_0000_FFFF_FB2E);
        run_op("not",         5'b10010, 32'h1234_5678,  32'hAAAA_AAAA,  64'h0000_0000_5555_5555);
        run_op("unused_1f",   5'b11111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0);
        run_op("mul_prime",   5'b01111, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001);
        run_op("unused_00",   5'b00000, 32'd5,          32'd5,          64'h0);
        run_op("add_prime",   5'b00011, 32'd1,          32'd2,          64'h0000_0000_0000_0003);
        run_op("unused_0c",   5'b01100, 32'd5,          32'd5,          64'h0);
        run_op("add_prime2",  5'b00011, 32'd1,          32'd2,          64'h0000_0000_0000_0003);
        run_op("unused_13",   5'b10011, 32'd5,          32'd5,          64'h0);

        // Mid-stream reset: a nonzero result must clear without waiting for a clock edge.
        run_op("pre_reset",   5'b00110, 32'h0000_FF00,  32'h0000_00FF,  64'h0000_0000_0000_FFFF);
        @(negedge clk);
        ctrl  = 5'b00011;
        reg_A = 32'd10;
        reg_B = 32'd20;
        clr   = 1'b0;
        #1;
        check("reset_mid", reg_C, 64'h0);
        @(posedge clk);
        #1;
        check("reset_mid_edge", reg_C, 64'h0);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        check("after_release", reg_C, 64'h0000_0000_0000_001E);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
